// File: rtl/gba_mem_arb_pkg.sv
// Shared types and helpers for the N-channel memory arbiter.
package gba_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    DONE
  } arb_state_t;

  localparam logic [1:0] W8  = 2'b01;
  localparam logic [1:0] W16 = 2'b10;
  localparam logic [1:0] W32 = 2'b11;

  function automatic logic [31:0] size_rd_data(input logic [1:0] width,
                                                input logic [31:0] data);
    case (width)
      W8:      size_rd_data = {24'b0, data[7:0]};
      W16:     size_rd_data = {16'b0, data[15:0]};
      default: size_rd_data = data;
    endcase
  endfunction

  // Width code 00 behaves as a full 32-bit access.
  function automatic logic [1:0] norm_width(input logic [1:0] width);
    norm_width = (width == 2'b00) ? W32 : width;
  endfunction

endpackage

// File: rtl/gba_rr_arbiter.sv
// Round-robin pick: combinational search from a registered start pointer.
module gba_rr_arbiter #(
  parameter int NUM_CH = 3,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  input  logic [IDX_W-1:0]  last_idx,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_CH);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (last_idx == IDX_W'(NUM_CH - 1)) ? '0 : last_idx + 1'b1;
    end
  end

endmodule

// File: rtl/gba_mem_arbiter.sv
// N-channel round-robin arbiter onto a single memory controller port.
// Optional: GBA_ARB_CH0_PRIO_EN gives channel 0 absolute priority.
module gba_mem_arbiter
  import gba_mem_arb_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_rd,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [NUM_CH*2-1:0]      ch_width,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]        ch_rd_valid,
  output logic [NUM_CH-1:0]        ch_wr_ack,
  output logic [NUM_CH-1:0]        ch_err,
  output logic [DATA_W-1:0]        ch_rd_data,
  output logic                     mem_rd,
  output logic                     mem_wr,
  input  logic                     mem_rd_ready,
  input  logic                     mem_wr_ready,
  input  logic                     mem_rd_valid,
  output logic [1:0]               mem_data_width,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wr_data,
  input  logic [DATA_W-1:0]        mem_rd_data
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  arb_state_t       state;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_rd;
  logic [CNT_W-1:0] rd_cnt;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] rr_req;
  logic [NUM_CH-1:0] rr_grant;
  logic [IDX_W-1:0]  rr_idx;
  logic [IDX_W-1:0]  win_idx;
  logic              win_valid;
  logic              advance;

  assign req = ch_rd | ch_wr;

`ifdef GBA_ARB_CH0_PRIO_EN
  // Channel 0 bypasses the rotation and never moves the pointer.
  assign rr_req    = req & ~NUM_CH'(1);
  assign win_valid = req[0] | (|rr_grant);
  assign win_idx   = req[0] ? '0 : rr_idx;
  assign advance   = (state == DONE) && (cur_idx != '0);
`else
  assign rr_req    = req;
  assign win_valid = |rr_grant;
  assign win_idx   = rr_idx;
  assign advance   = (state == DONE);
`endif

  gba_rr_arbiter #(
    .NUM_CH(NUM_CH),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (rr_req),
    .advance  (advance),
    .last_idx (cur_idx),
    .grant    (rr_grant),
    .grant_idx(rr_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cur_idx        <= '0;
      cur_rd         <= 1'b0;
      rd_cnt         <= '0;
      ch_rd_valid    <= '0;
      ch_wr_ack      <= '0;
      ch_err         <= '0;
      ch_rd_data     <= '0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_data_width <= '0;
      mem_addr       <= '0;
      mem_wr_data    <= '0;
    end else begin
      ch_rd_valid <= '0;
      ch_wr_ack   <= '0;
      ch_err      <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            cur_idx        <= win_idx;
            cur_rd         <= ch_rd[win_idx];
            mem_rd         <= ch_rd[win_idx];
            mem_wr         <= ~ch_rd[win_idx];
            mem_data_width <= norm_width(ch_width[win_idx*2 +: 2]);
            mem_addr       <= ch_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wr_data    <= ch_wr_data[win_idx*DATA_W +: DATA_W];
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (cur_rd) begin
            if (mem_rd_ready) begin
              mem_rd <= 1'b0;
              rd_cnt <= '0;
              state  <= WAIT_RD;
            end
          end else if (mem_wr_ready) begin
            mem_wr             <= 1'b0;
            ch_wr_ack[cur_idx] <= 1'b1;
            state              <= DONE;
          end
        end
        WAIT_RD: begin
          if (mem_rd_valid) begin
            ch_rd_data           <= size_rd_data(mem_data_width, mem_rd_data);
            ch_rd_valid[cur_idx] <= 1'b1;
            state                <= DONE;
          end else if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            ch_rd_data           <= '0;
            ch_rd_valid[cur_idx] <= 1'b1;
            ch_err[cur_idx]      <= 1'b1;
            state                <= DONE;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gba_mem_arbiter.sv
// Directed self-checking bench for gba_mem_arbiter.
module tb_gba_mem_arbiter;

  localparam int NUM_CH     = 3;
  localparam int ADDR_W     = 26;
  localparam int DATA_W     = 32;
  localparam int RD_TIMEOUT = 20;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH-1:0]        ch_rd;
  logic [NUM_CH-1:0]        ch_wr;
  logic [NUM_CH*2-1:0]      ch_width;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wr_data;
  logic [NUM_CH-1:0]        ch_rd_valid;
  logic [NUM_CH-1:0]        ch_wr_ack;
  logic [NUM_CH-1:0]        ch_err;
  logic [DATA_W-1:0]        ch_rd_data;
  logic                     mem_rd;
  logic                     mem_wr;
  logic                     mem_rd_ready;
  logic                     mem_wr_ready;
  logic                     mem_rd_valid;
  logic [1:0]               mem_data_width;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wr_data;
  logic [DATA_W-1:0]        mem_rd_data;

  int n_chk = 0;
  int n_bad = 0;
  int seq_exp[$];

  gba_mem_arbiter #(
    .NUM_CH    (NUM_CH),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ch_rd         (ch_rd),
    .ch_wr         (ch_wr),
    .ch_width      (ch_width),
    .ch_addr       (ch_addr),
    .ch_wr_data    (ch_wr_data),
    .ch_rd_valid   (ch_rd_valid),
    .ch_wr_ack     (ch_wr_ack),
    .ch_err        (ch_err),
    .ch_rd_data    (ch_rd_data),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_rd_ready  (mem_rd_ready),
    .mem_wr_ready  (mem_wr_ready),
    .mem_rd_valid  (mem_rd_valid),
    .mem_data_width(mem_data_width),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=no finish exp=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [1:0] w, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d);
    ch_width[ch*2 +: 2]             = w;
    ch_addr[ch*ADDR_W +: ADDR_W]    = a;
    ch_wr_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic wait_mem_wr;
    int n;
    n = 0;
    while (mem_wr !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    check("mem_wr_seen", 64'(mem_wr), 64'd1);
  endtask

  // Read with valid returned two cycles after the accept cycle.
  task automatic do_read(input int ch, input logic [1:0] w, input logic [ADDR_W-1:0] a,
                         input logic [31:0] rdat, input logic [31:0] exp, input string tag);
    set_ch(ch, w, a, 32'h0);
    ch_rd[ch]    = 1'b1;
    mem_rd_ready = 1'b1;
    tick;
    check({tag, "_mem_rd"}, 64'(mem_rd), 64'd1);
    check({tag, "_addr"}, 64'(mem_addr), 64'(a));
    check({tag, "_width"}, 64'(mem_data_width), 64'((w == 2'b00) ? 2'b11 : w));
    tick;
    check({tag, "_rd_drop"}, 64'(mem_rd), 64'd0);
    tick;
    mem_rd_valid = 1'b1;
    mem_rd_data  = rdat;
    check({tag, "_no_early"}, 64'(ch_rd_valid), 64'd0);
    tick;
    check({tag, "_valid"}, 64'(ch_rd_valid), 64'(NUM_CH'(1) << ch));
    check({tag, "_data"}, 64'(ch_rd_data), 64'(exp));
    check({tag, "_err"}, 64'(ch_err), 64'd0);
    mem_rd_valid = 1'b0;
    ch_rd[ch]    = 1'b0;
    tick;
    check({tag, "_pulse"}, 64'(ch_rd_valid), 64'd0);
  endtask

  initial begin
    logic early;
    rst_n        = 1'b0;
    ch_rd        = '0;
    ch_wr        = '0;
    ch_width     = '0;
    ch_addr      = '0;
    ch_wr_data   = '0;
    mem_rd_ready = 1'b0;
    mem_wr_ready = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    repeat (3) tick;
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wr_data), 64'd0);
    check("rst_width", 64'(mem_data_width), 64'd0);
    check("rst_rvalid", 64'(ch_rd_valid), 64'd0);
    check("rst_ack", 64'(ch_wr_ack), 64'd0);
    check("rst_err", 64'(ch_err), 64'd0);
    check("rst_rdata", 64'(ch_rd_data), 64'd0);
    rst_n = 1'b1;
    tick;

    // Single write on ch1
    set_ch(1, 2'b11, 26'h0000100, 32'hDEADBEEF);
    ch_wr[1]     = 1'b1;
    mem_wr_ready = 1'b1;
    tick;
    check("wr_mem_wr", 64'(mem_wr), 64'd1);
    check("wr_addr", 64'(mem_addr), 64'h100);
    check("wr_data", 64'(mem_wr_data), 64'hDEADBEEF);
    check("wr_width", 64'(mem_data_width), 64'd3);
    check("wr_ack_early", 64'(ch_wr_ack), 64'd0);
    tick;
    check("wr_ack", 64'(ch_wr_ack), 64'b010);
    check("wr_drop", 64'(mem_wr), 64'd0);
    ch_wr[1] = 1'b0;
    tick;
    check("wr_ack_pulse", 64'(ch_wr_ack), 64'd0);

    do_read(0, 2'b01, 26'h40, 32'h12345678, 32'h00000078, "rd8");
    do_read(0, 2'b10, 26'h44, 32'h12345678, 32'h00005678, "rd16");
    do_read(2, 2'b00, 26'h48, 32'h12345678, 32'h12345678, "rd32");

    // Read timeout on ch2
    set_ch(2, 2'b11, 26'h2222, 32'h0);
    ch_rd[2]     = 1'b1;
    mem_rd_ready = 1'b1;
    tick;
    check("to_mem_rd", 64'(mem_rd), 64'd1);
    tick;
    early = 1'b0;
    for (int i = 0; i < RD_TIMEOUT; i++) begin
      if (ch_rd_valid != '0) early = 1'b1;
      tick;
    end
    check("to_early", 64'(early), 64'd0);
    check("to_valid", 64'(ch_rd_valid), 64'b100);
    check("to_err", 64'(ch_err), 64'b100);
    check("to_data", 64'(ch_rd_data), 64'd0);
    ch_rd[2] = 1'b0;
    tick;
    check("to_err_pulse", 64'(ch_err), 64'd0);
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'hAAAA5555;
    tick;
    tick;
    check("late_valid", 64'(ch_rd_valid), 64'd0);
    check("late_data", 64'(ch_rd_data), 64'd0);
    check("late_mem_rd", 64'(mem_rd), 64'd0);
    mem_rd_valid = 1'b0;

    // Write back-pressure on ch0; input changes during hold must not leak out
    set_ch(0, 2'b01, 26'h2A0, 32'hCAFEF00D);
    ch_wr[0]     = 1'b1;
    mem_wr_ready = 1'b0;
    tick;
    check("bp_mem_wr", 64'(mem_wr), 64'd1);
    set_ch(0, 2'b10, 26'h3FFFFFF, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_hold", 64'(mem_wr), 64'd1);
      check("bp_addr", 64'(mem_addr), 64'h2A0);
      check("bp_data", 64'(mem_wr_data), 64'hCAFEF00D);
    end
    check("bp_width", 64'(mem_data_width), 64'd1);
    check("bp_no_ack", 64'(ch_wr_ack), 64'd0);
    mem_wr_ready = 1'b1;
    tick;
    check("bp_ack", 64'(ch_wr_ack), 64'b001);
    check("bp_drop", 64'(mem_wr), 64'd0);
    ch_wr[0] = 1'b0;
    tick;

    // Reset in the middle of WAIT_RD
    do_read(1, 2'b10, 26'h300, 32'hBEEF1234, 32'h00001234, "rd_pre");
    set_ch(1, 2'b11, 26'h1234, 32'h0);
    ch_rd[1] = 1'b1;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    check("mrst_mem_rd", 64'(mem_rd), 64'd0);
    check("mrst_addr", 64'(mem_addr), 64'd0);
    check("mrst_width", 64'(mem_data_width), 64'd0);
    check("mrst_rdata", 64'(ch_rd_data), 64'd0);
    check("mrst_rvalid", 64'(ch_rd_valid), 64'd0);
    rst_n        = 1'b1;
    ch_rd        = '0;
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'hFFFFFFFF;
    tick;
    check("mrst_stale", 64'(ch_rd_valid), 64'd0);
    mem_rd_valid = 1'b0;
    set_ch(2, 2'b11, 26'h55, 32'h77);
    ch_wr[2] = 1'b1;
    tick;
    check("mrst_idle_wr", 64'(mem_wr), 64'd1);
    check("mrst_idle_addr", 64'(mem_addr), 64'h55);
    tick;
    check("mrst_idle_ack", 64'(ch_wr_ack), 64'b100);
    ch_wr = '0;
    tick;

    // Arbitration order with all channels requesting writes
`ifdef GBA_ARB_CH0_PRIO_EN
    seq_exp = '{0, 0, 0, 1, 2};
`else
    seq_exp = '{0, 1, 2, 0, 1, 2};
`endif
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 2'b11, ADDR_W'((c + 1) * 16), 32'(c));
    ch_wr = '1;
    for (int k = 0; k < seq_exp.size(); k++) begin
      wait_mem_wr;
      check("rr_addr", 64'(mem_addr), 64'((seq_exp[k] + 1) * 16));
      tick;
      check("rr_ack", 64'(ch_wr_ack), 64'(NUM_CH'(1) << seq_exp[k]));
`ifdef GBA_ARB_CH0_PRIO_EN
      if (k == 2) ch_wr[0] = 1'b0;
`endif
      if (k == seq_exp.size() - 1) ch_wr = '0;
    end
    repeat (3) tick;
    check("rr_quiet", 64'(mem_wr), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
